// File: rtl/sigma_driver.sv
// Initiator for the sigma engine: gathers a 3x3 float32 matrix,
// fires sigma, times its answer and hands the result downstream.
module sigma_driver #(
  parameter int              PRECISION = 32,
  parameter logic [31:0]     ERR_VAL   = 32'h3dcccccd,
  parameter int              TIMEOUT   = 4096,
  parameter int              LAT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PRECISION-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [PRECISION-1:0] err,
  output logic [PRECISION-1:0] A00,
  output logic [PRECISION-1:0] A01,
  output logic [PRECISION-1:0] A02,
  output logic [PRECISION-1:0] A10,
  output logic [PRECISION-1:0] A11,
  output logic [PRECISION-1:0] A12,
  output logic [PRECISION-1:0] A20,
  output logic [PRECISION-1:0] A21,
  output logic [PRECISION-1:0] A22,
  output logic                 tvalid,
  input  logic                 sig_valid,
  input  logic [PRECISION-1:0] sig_data,
  output logic [PRECISION-1:0] m_sigma,
  output logic [LAT_W-1:0]     m_latency,
  output logic                 m_timeout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  localparam logic [LAT_W-1:0]     TO_L = LAT_W'(TIMEOUT);
  localparam logic [PRECISION-1:0] QNAN = PRECISION'(32'h7fc00000);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             idx;
  logic [PRECISION-1:0]   a_q [9];
  logic [LAT_W-1:0]       lat;
  logic [LAT_W-1:0]       lat_inc;
  logic                   accept;
  logic                   sig_hit;
  logic                   to_hit;

  assign err = PRECISION'(ERR_VAL);

  // Count as seen in the current cycle; holds at all-ones.
  assign lat_inc = (lat == '1) ? lat : lat + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    tvalid    = 1'b0;
    m_valid   = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    sig_hit   = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) begin
          accept = 1'b1;
          if (idx == 4'd8) begin
            state_nxt = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        tvalid    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A real answer beats the abort when both land together.
        if (sig_valid) begin
          sig_hit   = 1'b1;
          state_nxt = S_HOLD;
        end else if (lat_inc == TO_L) begin
          to_hit    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      lat       <= '0;
      m_sigma   <= '0;
      m_latency <= '0;
      m_timeout <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        a_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        a_q[idx] <= s_data;
        idx      <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
      end
      if (state == S_FIRE) begin
        lat <= '0;
      end else if (state == S_WAIT) begin
        lat <= lat_inc;
      end
      if (sig_hit) begin
        m_sigma   <= sig_data;
        m_latency <= lat_inc;
        m_timeout <= 1'b0;
      end else if (to_hit) begin
        m_sigma   <= QNAN;
        m_latency <= TO_L;
        m_timeout <= 1'b1;
      end
    end
  end

  assign A00 = a_q[0];
  assign A01 = a_q[1];
  assign A02 = a_q[2];
  assign A10 = a_q[3];
  assign A11 = a_q[4];
  assign A12 = a_q[5];
  assign A20 = a_q[6];
  assign A21 = a_q[7];
  assign A22 = a_q[8];

endmodule

// File: tb/tb_sigma_driver.sv
// Directed bench for sigma_driver with a timestamp-based reference
// model compared on every falling edge.
module tb_sigma_driver;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        sig_valid = 1'b0;
  logic [31:0] sig_data = '0;
  logic        m_ready = 1'b0;

  logic        s_ready;
  logic [31:0] err;
  logic [31:0] a_o [9];
  logic        tvalid;
  logic [31:0] m_sigma;
  logic [15:0] m_latency;
  logic        m_timeout;
  logic        m_valid;
  logic        busy;

  sigma_driver #(
    .PRECISION(32),
    .ERR_VAL  (32'h3dcccccd),
    .TIMEOUT  (TO),
    .LAT_W    (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .err      (err),
    .A00      (a_o[0]),
    .A01      (a_o[1]),
    .A02      (a_o[2]),
    .A10      (a_o[3]),
    .A11      (a_o[4]),
    .A12      (a_o[5]),
    .A20      (a_o[6]),
    .A21      (a_o[7]),
    .A22      (a_o[8]),
    .tvalid   (tvalid),
    .sig_valid(sig_valid),
    .sig_data (sig_data),
    .m_sigma  (m_sigma),
    .m_latency(m_latency),
    .m_timeout(m_timeout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: beats collected, cycles elapsed since the start
  // pulse (-1 = no matrix outstanding), and the result on offer.
  logic [31:0] e_a [9];
  int          e_n;
  int          since_fire;
  bit          e_held;
  logic [31:0] e_sig;
  logic [31:0] e_lat;
  bit          e_to;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) e_a[i] = '0;
    e_n        = 0;
    since_fire = -1;
    e_held     = 0;
    e_sig      = '0;
    e_lat      = '0;
    e_to       = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else if (e_held) begin
        if (m_ready) e_held = 0;
      end else if (since_fire < 0) begin
        if (s_valid) begin
          e_a[e_n] = s_data;
          e_n++;
          if (e_n == 9) begin
            e_n = 0;
            since_fire = 0;
          end
        end
      end else if (since_fire == 0) begin
        since_fire = 1;
      end else if (sig_valid) begin
        e_sig = sig_data;
        e_lat = since_fire;
        e_to = 0;
        e_held = 1;
        since_fire = -1;
      end else if (since_fire == TO) begin
        e_sig = 32'h7fc00000;
        e_lat = TO;
        e_to = 1;
        e_held = 1;
        since_fire = -1;
      end else begin
        since_fire++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready", s_ready, (since_fire < 0 && !e_held));
      chk("busy", busy, !(since_fire < 0 && !e_held));
      chk("tvalid", tvalid, (since_fire == 0));
      chk("m_valid", m_valid, e_held);
      chk("err", err, 32'h3dcccccd);
      chk("m_sigma", m_sigma, e_sig);
      chk("m_latency", m_latency, e_lat);
      chk("m_timeout", m_timeout, e_to);
      for (int i = 0; i < 9; i++) chk($sformatf("A[%0d]", i), a_o[i], e_a[i]);
    end
  end

  logic [31:0] vec [9];

  task automatic load(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = vec[i];
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = 32'hdeadbeef;
      if (gap && i < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic respond(input int d, input logic [31:0] data);
    repeat (d) @(posedge clk);
    #1;
    sig_valid = 1'b1;
    sig_data  = data;
    @(posedge clk); #1;
    sig_valid = 1'b0;
    sig_data  = 32'h0badf00d;
  endtask

  task automatic release_result(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("hold_m_valid", m_valid, 1);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("rel_m_valid", m_valid, 0);
    chk("rel_s_ready", s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1/2: back-to-back load, answer 7 cycles after the pulse
    vec = '{32'h0, 32'h3f000000, 32'h3d4ccccd, 32'h3eaaaaaa, 32'h0,
            32'h3eaaaaaa, 32'h3d4ccccd, 32'h3f000000, 32'h0};
    load(9, 0);
    chk("t1_tvalid", tvalid, 1);
    chk("t1_s_ready", s_ready, 0);
    respond(7, 32'h3f800000);
    chk("t1_A01", a_o[1], 32'h3f000000);
    chk("t1_A20", a_o[6], 32'h3d4ccccd);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_sigma", m_sigma, 32'h3f800000);
    chk("t2_m_latency", m_latency, 7);
    chk("t2_m_timeout", m_timeout, 0);
    release_result(5);

    // 3: silent sigma -> abort at TIMEOUT
    vec = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9};
    load(9, 0);
    chk("t3_tvalid", tvalid, 1);
    cyc = 0;
    for (int i = 0; i < 40 && !m_valid; i++) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t3_cycles_to_m_valid", cyc, TO + 1);
    chk("t3_m_sigma", m_sigma, 32'h7fc00000);
    chk("t3_m_timeout", m_timeout, 1);
    chk("t3_m_latency", m_latency, TO);
    release_result(2);

    // 6a: stray sig_valid during LOAD; 4: gapped input stream
    sig_valid = 1'b1;
    sig_data  = 32'h12345678;
    @(posedge clk); #1;
    sig_valid = 1'b0;
    chk("t6_load_ignored", m_valid, 0);
    vec = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
            32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000,
            32'h41200000};
    load(9, 1);
    chk("t4_tvalid", tvalid, 1);
    respond(3, 32'h40490fdb);
    chk("t4_A12", a_o[5], 32'h40e00000);
    chk("t4_A00", a_o[0], 32'h40000000);
    chk("t4_m_latency", m_latency, 3);
    release_result(1);

    // 5: reset after a partial load, then a full load
    vec = '{32'haaaa0000, 32'haaaa0001, 32'haaaa0002, 32'haaaa0003,
            32'haaaa0004, 32'h0, 32'h0, 32'h0, 32'h0};
    load(5, 0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_A00", a_o[0], 0);
    chk("t5_rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vec = '{32'hbbbb0000, 32'hbbbb0001, 32'hbbbb0002, 32'hbbbb0003,
            32'hbbbb0004, 32'hbbbb0005, 32'hbbbb0006, 32'hbbbb0007,
            32'hbbbb0008};
    load(9, 0);
    chk("t5_tvalid", tvalid, 1);
    respond(2, 32'h3e800000);
    chk("t5_m_latency", m_latency, 2);
    chk("t5_A22", a_o[8], 32'hbbbb0008);
    release_result(0);

    // 6b: answer on the timeout cycle wins; stray pulse in HOLD
    vec = '{32'hc0000000, 32'hc0000001, 32'hc0000002, 32'hc0000003,
            32'hc0000004, 32'hc0000005, 32'hc0000006, 32'hc0000007,
            32'hc0000008};
    load(9, 0);
    respond(TO, 32'h3f400000);
    chk("t6_m_timeout", m_timeout, 0);
    chk("t6_m_latency", m_latency, TO);
    chk("t6_m_sigma", m_sigma, 32'h3f400000);
    sig_valid = 1'b1;
    sig_data  = 32'hffffffff;
    @(posedge clk); #1;
    sig_valid = 1'b0;
    chk("t6_hold_m_sigma", m_sigma, 32'h3f400000);
    release_result(1);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
